focus_peak_search: RTL and testbench
====================================

Name: focus_peak_search

Overview:
- Closed-loop partner of the VCM sweep generator. It consumes the lens STEP position, the coarse/fine phase flags and a per-frame sharpness measure.
- It returns STEP_UP, the best coarse position, which the sweep generator uses to centre its fine pass.
- After the fine pass it publishes FINAL_STEP, the focus position the lens should park at.
- Sits between the sharpness accumulator (image pipe, one result per frame) and the VCM sweep/I2C driver chain.

Parameters:
- SHARP_W, 24, width of the per-frame sharpness sum.
- STEP_W, 11, width of the incoming STEP bus.
- SKIP_FRAMES, 1, sharpness results discarded after every STEP change (lens settle). Legal range 0..7.

Ports:
- CLK  input  1  system clock.
- RESET_n  input  1  asynchronous, active-low reset.
- STEP  input  STEP_W  current lens position from the sweep generator.
- V_C  input  1  phase flag: 0 = coarse sweep, 1 = fine sweep.
- VCM_END  input  1  fine sweep finished (level, sticky high).
- SHARP_VALID  input  1  one-cycle strobe; SHARP is valid on this cycle.
- SHARP  input  SHARP_W  frame sharpness measure.
- STEP_UP  output  10  best coarse step; held constant during the fine phase.
- FINAL_STEP  output  STEP_W  best fine step.
- PEAK_VAL  output  SHARP_W  sharpness of the current best.
- DONE  output  1  search complete (sticky).

Behaviour:
- Reset values: STEP_UP=0, FINAL_STEP=0, PEAK_VAL=0, DONE=0, state=COARSE, skip counter=SKIP_FRAMES, best_step=0, STEP_d=0.
- States:
  - COARSE: V_C rising edge goes to FINE.
  - FINE: VCM_END rising edge goes to DONE.
  - DONE: stays in DONE until reset.
  - Edges are detected against 1-cycle registered copies of V_C and VCM_END. A V_C falling edge in any state returns to COARSE and clears best, skip and DONE.
- Settle:
  - STEP_d is a registered copy of STEP.
  - When STEP != STEP_d, the skip counter reloads SKIP_FRAMES.
  - A SHARP_VALID strobe while skip > 0 decrements skip and is discarded.
  - A SHARP_VALID strobe on the same cycle as a STEP change is discarded, and the counter reloads without decrementing.
- Accept: a SHARP_VALID strobe with skip == 0 in COARSE or FINE is compared against PEAK_VAL.
  - If SHARP > PEAK_VAL (strict, unsigned), then on the next edge PEAK_VAL <= SHARP and best_step <= STEP.
  - On ties the earlier step wins.
  - Several frames at one step are all compared.
  - Strobes in DONE are ignored.
- Coarse to fine: on the cycle the V_C rising edge is detected:
  - STEP_UP <= best_step saturated to 10 bits (best_step > 1023 gives 1023).
  - PEAK_VAL <= 0, best_step <= {1'b0, STEP_UP_next}, skip reloads.
  - If no sample was accepted during COARSE, STEP_UP=0.
  - A SHARP_VALID strobe on this same cycle is discarded.
- Fine to done: on the VCM_END rising edge, FINAL_STEP <= best_step and DONE <= 1. A strobe on this same cycle is still compared first, and FINAL_STEP takes the updated best.
- Latency: 1 CLK from SHARP_VALID to PEAK_VAL update; 1 CLK from the detected edge to STEP_UP/FINAL_STEP/DONE.
- STEP_UP changes only at the coarse-to-fine transition and on reset. The sweep generator's fine comparisons therefore stay stable.
- Reset mid-search: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro FOCUS_SAMPLE_CNT_EN.
- Defined: adds output SAMPLE_CNT[15:0].
  - Counts accepted (non-discarded) samples in the current phase.
  - Saturates at 16'hFFFF.
  - Clears on reset and at the coarse-to-fine transition.
  - Frozen in DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package focus_pkg:
  - state enum (COARSE, FINE, DONE, 2 bits).
  - STEP_UP_W=10 and STEP_UP_MAX=10'd1023.
  - SKIP_CNT_W=3.
- One sub-module, focus_settle_gate:
  - Inputs: STEP, SHARP_VALID, phase-reload.
  - Output: accept strobe.
  - Contains STEP_d and the skip counter.
- Compare/track logic and the FSM stay in the top.

Test Plan:
- SKIP_FRAMES=1, coarse sweep steps 0,10,...,1010, one strobe per frame (two frames per step), SHARP peaks at 1000 when STEP=500 -> after V_C rises, STEP_UP=500, PEAK_VAL=0.
- Equal SHARP=800 at steps 300 and 400 -> STEP_UP=300 (tie keeps earliest).
- Fine sweep 495..506, peak 1200 at 498, then VCM_END rises -> FINAL_STEP=498, DONE=1 one cycle after the edge, later strobes ignored.
- SHARP_VALID coincident with a STEP change (STEP 20 to 30, SHARP=FFFFFF) -> discarded; PEAK_VAL unchanged; next strobe also skipped.
- No accepted samples before V_C rises -> STEP_UP=0. Best step 1020 in coarse -> STEP_UP=1020. Best step 11'h410 -> STEP_UP=1023 (saturation).
- RESET_n pulsed low mid-FINE -> all outputs 0 asynchronously, state COARSE. With FOCUS_SAMPLE_CNT_EN defined, SAMPLE_CNT=0 after reset and counts 3 after three accepted strobes.

Source files
------------

// File: rtl/focus_pkg.sv
// Shared types and constants for the focus peak search block.
package focus_pkg;

   typedef enum logic [1:0] {
      ST_COARSE = 2'd0,
      ST_FINE   = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int                    STEP_UP_W   = 10;
   localparam logic [STEP_UP_W-1:0]  STEP_UP_MAX = 10'd1023;
   localparam int                    SKIP_CNT_W  = 3;

   // Clamp a lens position into the 10-bit STEP_UP range.
   function automatic logic [STEP_UP_W-1:0] sat_step_up(input logic [31:0] step);
      return (step > 32'(STEP_UP_MAX)) ? STEP_UP_MAX : step[STEP_UP_W-1:0];
   endfunction

endpackage

// File: rtl/focus_settle_gate.sv
// Lens-settle gate: discards sharpness strobes for SKIP_FRAMES results after
// every STEP change and on a phase reload.
module focus_settle_gate
   import focus_pkg::*;
#(
   parameter int STEP_W      = 11,
   parameter int SKIP_FRAMES = 1
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic [STEP_W-1:0] STEP,
   input  logic              SHARP_VALID,
   input  logic              reload,
   output logic              accept
);

   localparam logic [SKIP_CNT_W-1:0] SKIP_INIT = SKIP_CNT_W'(SKIP_FRAMES);

   logic [STEP_W-1:0]     step_d;
   logic [SKIP_CNT_W-1:0] skip;
   logic                  step_chg;

   assign step_chg = (STEP != step_d);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         step_d <= '0;
         skip   <= SKIP_INIT;
      end else begin
         step_d <= STEP;
         if (step_chg || reload)
            skip <= SKIP_INIT;
         else if (SHARP_VALID && (skip != '0))
            skip <= skip - SKIP_CNT_W'(1);
      end
   end

   // A strobe coinciding with a position change belongs to a moving lens.
   assign accept = SHARP_VALID && !step_chg && !reload && (skip == '0);

endmodule

// File: rtl/focus_peak_search.sv
// Coarse/fine autofocus peak tracker. Optional SAMPLE_CNT output is enabled
// by defining FOCUS_SAMPLE_CNT_EN.
module focus_peak_search
   import focus_pkg::*;
#(
   parameter int SHARP_W     = 24,
   parameter int STEP_W      = 11,
   parameter int SKIP_FRAMES = 1
) (
   input  logic                 CLK,
   input  logic                 RESET_n,
   input  logic [STEP_W-1:0]    STEP,
   input  logic                 V_C,
   input  logic                 VCM_END,
   input  logic                 SHARP_VALID,
   input  logic [SHARP_W-1:0]   SHARP,
   output logic [STEP_UP_W-1:0] STEP_UP,
   output logic [STEP_W-1:0]    FINAL_STEP,
   output logic [SHARP_W-1:0]   PEAK_VAL,
   output logic                 DONE
`ifdef FOCUS_SAMPLE_CNT_EN
   ,
   output logic [15:0]          SAMPLE_CNT
`endif
);

   state_t               state;
   logic                 v_c_d;
   logic                 vcm_end_d;
   logic [STEP_W-1:0]    best_step;
   logic                 accept;
   logic                 v_c_rise;
   logic                 v_c_fall;
   logic                 vcm_rise;
   logic                 reload;
   logic                 active;
   logic                 take;
   logic [STEP_UP_W-1:0] step_up_next;

   assign v_c_rise     = V_C & ~v_c_d;
   assign v_c_fall     = ~V_C & v_c_d;
   assign vcm_rise     = VCM_END & ~vcm_end_d;
   assign reload       = ((state == ST_COARSE) && v_c_rise) || v_c_fall;
   assign active       = accept && (state != ST_DONE);
   assign take         = active && (SHARP > PEAK_VAL);
   assign step_up_next = sat_step_up(32'(best_step));

   focus_settle_gate #(
      .STEP_W      (STEP_W),
      .SKIP_FRAMES (SKIP_FRAMES)
   ) u_settle (
      .CLK         (CLK),
      .RESET_n     (RESET_n),
      .STEP        (STEP),
      .SHARP_VALID (SHARP_VALID),
      .reload      (reload),
      .accept      (accept)
   );

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= ST_COARSE;
         v_c_d      <= 1'b0;
         vcm_end_d  <= 1'b0;
         best_step  <= '0;
         STEP_UP    <= '0;
         FINAL_STEP <= '0;
         PEAK_VAL   <= '0;
         DONE       <= 1'b0;
      end else begin
         v_c_d     <= V_C;
         vcm_end_d <= VCM_END;
         if (v_c_fall) begin
            state     <= ST_COARSE;
            PEAK_VAL  <= '0;
            best_step <= '0;
            DONE      <= 1'b0;
         end else begin
            if (take) begin
               PEAK_VAL  <= SHARP;
               best_step <= STEP;
            end
            case (state)
               ST_COARSE: begin
                  // The fine pass restarts its peak search around the coarse best.
                  if (v_c_rise) begin
                     state     <= ST_FINE;
                     STEP_UP   <= step_up_next;
                     PEAK_VAL  <= '0;
                     best_step <= STEP_W'(step_up_next);
                  end
               end
               ST_FINE: begin
                  if (vcm_rise) begin
                     state      <= ST_DONE;
                     DONE       <= 1'b1;
                     FINAL_STEP <= take ? STEP : best_step;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef FOCUS_SAMPLE_CNT_EN
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)
         SAMPLE_CNT <= '0;
      else if ((state == ST_COARSE) && v_c_rise && !v_c_fall)
         SAMPLE_CNT <= '0;
      else if (active && (SAMPLE_CNT != 16'hFFFF))
         SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
   end
`endif

endmodule

// File: tb/tb_focus_peak_search.sv
// Scoreboard bench for focus_peak_search: stimulus queues expected output
// changes, a negedge monitor pops and compares them as outputs move.
module tb_focus_peak_search;

   localparam int SHARP_W = 24;
   localparam int STEP_W  = 11;

   logic               CLK = 1'b0;
   logic               RESET_n = 1'b0;
   logic [STEP_W-1:0]  STEP = '0;
   logic               V_C = 1'b0;
   logic               VCM_END = 1'b0;
   logic               SHARP_VALID = 1'b0;
   logic [SHARP_W-1:0] SHARP = '0;
   logic [9:0]         STEP_UP;
   logic [STEP_W-1:0]  FINAL_STEP;
   logic [SHARP_W-1:0] PEAK_VAL;
   logic               DONE;
`ifdef FOCUS_SAMPLE_CNT_EN
   logic [15:0]        SAMPLE_CNT;
`endif

   always #5 CLK = ~CLK;

   focus_peak_search #(
      .SHARP_W     (SHARP_W),
      .STEP_W      (STEP_W),
      .SKIP_FRAMES (1)
   ) dut (
      .CLK         (CLK),
      .RESET_n     (RESET_n),
      .STEP        (STEP),
      .V_C         (V_C),
      .VCM_END     (VCM_END),
      .SHARP_VALID (SHARP_VALID),
      .SHARP       (SHARP),
      .STEP_UP     (STEP_UP),
      .FINAL_STEP  (FINAL_STEP),
      .PEAK_VAL    (PEAK_VAL),
      .DONE        (DONE)
`ifdef FOCUS_SAMPLE_CNT_EN
      ,
      .SAMPLE_CNT  (SAMPLE_CNT)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] peak_q[$];
   logic [31:0] up_q[$];
   logic [31:0] fin_q[$];
   logic [31:0] done_q[$];
   logic [31:0] last_peak = '0;
   logic [31:0] last_up   = '0;
   logic [31:0] last_fin  = '0;
   logic [31:0] last_done = '0;
   bit          mon_en    = 1'b0;
   int          exp_peak  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every observed output change must match the next queued value.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (32'(PEAK_VAL) !== last_peak) begin
            if (peak_q.size() == 0) check("peak_unexpected", 32'(PEAK_VAL), last_peak);
            else                    check("peak", 32'(PEAK_VAL), peak_q.pop_front());
            last_peak = 32'(PEAK_VAL);
         end
         if (32'(STEP_UP) !== last_up) begin
            if (up_q.size() == 0) check("step_up_unexpected", 32'(STEP_UP), last_up);
            else                  check("step_up", 32'(STEP_UP), up_q.pop_front());
            last_up = 32'(STEP_UP);
         end
         if (32'(FINAL_STEP) !== last_fin) begin
            if (fin_q.size() == 0) check("final_unexpected", 32'(FINAL_STEP), last_fin);
            else                   check("final_step", 32'(FINAL_STEP), fin_q.pop_front());
            last_fin = 32'(FINAL_STEP);
         end
         if (32'(DONE) !== last_done) begin
            if (done_q.size() == 0) check("done_unexpected", 32'(DONE), last_done);
            else                    check("done", 32'(DONE), done_q.pop_front());
            last_done = 32'(DONE);
         end
      end
   end

   task automatic expect_accept(input int v);
      if (v > exp_peak) begin
         exp_peak = v;
         peak_q.push_back(32'(v));
      end
   endtask

   task automatic expect_clear();
      if (exp_peak != 0) peak_q.push_back(32'd0);
      exp_peak = 0;
   endtask

   task automatic set_step(input int s);
      @(posedge CLK); #1 STEP = STEP_W'(s);
   endtask

   task automatic strobe(input int v);
      @(posedge CLK); #1 SHARP = SHARP_W'(v); SHARP_VALID = 1'b1;
      @(posedge CLK); #1 SHARP_VALID = 1'b0;
   endtask

   // One lens step: first frame is lost to settling, second is scored.
   task automatic frame(input int s, input int discard_v, input int keep_v);
      set_step(s);
      strobe(discard_v);
      strobe(keep_v);
   endtask

   task automatic set_vc(input logic v);
      @(posedge CLK); #1 V_C = v;
      @(posedge CLK); #1;
   endtask

   task automatic fall_all();
      @(posedge CLK); #1 V_C = 1'b0; VCM_END = 1'b0;
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      check("rst_step_up", 32'(STEP_UP), 32'd0);
      check("rst_final", 32'(FINAL_STEP), 32'd0);
      check("rst_peak", 32'(PEAK_VAL), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      #22 RESET_n = 1'b1;
      mon_en = 1'b1;

      // Coarse sweep 0..1010, peak 1000 at step 500.
      for (int s = 0; s <= 1010; s += 10) begin
         int v;
         v = (s > 500) ? (1000 - (s - 500)) : (1000 - (500 - s));
         expect_accept(v);
         frame(s, 5000, v);
      end
      check("peak_coarse", 32'(PEAK_VAL), 32'd1000);
      up_q.push_back(32'd500);
      expect_clear();
      set_vc(1'b1);
      check("step_up_coarse", 32'(STEP_UP), 32'd500);
      check("peak_after_rise", 32'(PEAK_VAL), 32'd0);

      // Fine sweep 495..506, peak 1200 at 498.
      for (int s = 495; s <= 506; s++) begin
         int v;
         v = (s > 498) ? (1200 - 10 * (s - 498)) : (1200 - 10 * (498 - s));
         expect_accept(v);
         frame(s, 5000, v);
      end
      fin_q.push_back(32'd498);
      done_q.push_back(32'd1);
      @(posedge CLK); #1 VCM_END = 1'b1;
      @(negedge CLK);
      check("done_before_edge", 32'(DONE), 32'd0);
      @(posedge CLK); #1;
      check("done_latency", 32'(DONE), 32'd1);
      check("final_fine", 32'(FINAL_STEP), 32'd498);
      frame(600, 5000, 24'hFFFFFF);
      check("peak_after_done", 32'(PEAK_VAL), 32'd1200);
      check("step_up_held", 32'(STEP_UP), 32'd500);

      // Tie at 800: earliest step wins.
      done_q.push_back(32'd0);
      expect_clear();
      fall_all();
      expect_accept(500); frame(100, 5000, 500);
      expect_accept(800); frame(300, 5000, 800);
      expect_accept(800); frame(400, 5000, 800);
      expect_accept(700); frame(500, 5000, 700);
      up_q.push_back(32'd300);
      expect_clear();
      set_vc(1'b1);
      check("step_up_tie", 32'(STEP_UP), 32'd300);
      set_vc(1'b0);

      // Strobe coincident with a step change, then the settle frame.
      expect_accept(100); frame(20, 5000, 100);
      @(posedge CLK); #1 STEP = STEP_W'(30); SHARP = 24'hFFFFFF; SHARP_VALID = 1'b1;
      @(posedge CLK); #1 SHARP_VALID = 1'b0;
      strobe(24'hFFFFFF);
      check("peak_coincident", 32'(PEAK_VAL), 32'd100);
      expect_accept(150); strobe(150);
      up_q.push_back(32'd30);
      expect_clear();
      set_vc(1'b1);
      set_vc(1'b0);

      // No accepted samples in coarse.
      up_q.push_back(32'd0);
      set_vc(1'b1);
      check("step_up_empty", 32'(STEP_UP), 32'd0);
      set_vc(1'b0);

      // Best at 1020 fits in 10 bits.
      expect_accept(50); frame(1020, 5000, 50);
      up_q.push_back(32'd1020);
      expect_clear();
      set_vc(1'b1);
      check("step_up_1020", 32'(STEP_UP), 32'd1020);
      set_vc(1'b0);

      // Best at 11'h410 saturates; an empty fine pass parks at the clamp.
      expect_accept(60); frame(11'h410, 5000, 60);
      up_q.push_back(32'd1023);
      expect_clear();
      set_vc(1'b1);
      check("step_up_sat", 32'(STEP_UP), 32'd1023);
      fin_q.push_back(32'd1023);
      done_q.push_back(32'd1);
      @(posedge CLK); #1 VCM_END = 1'b1;
      @(posedge CLK); #1;
      check("final_empty_fine", 32'(FINAL_STEP), 32'd1023);
      done_q.push_back(32'd0);
      fall_all();

      // Asynchronous reset in the middle of the fine pass.
      expect_accept(70); frame(200, 5000, 70);
      up_q.push_back(32'd200);
      expect_clear();
      set_vc(1'b1);
      expect_accept(90); frame(205, 5000, 90);
      up_q.push_back(32'd0);
      fin_q.push_back(32'd0);
      expect_clear();
      @(posedge CLK); #2 RESET_n = 1'b0;
      #1;
      check("async_step_up", 32'(STEP_UP), 32'd0);
      check("async_peak", 32'(PEAK_VAL), 32'd0);
      check("async_final", 32'(FINAL_STEP), 32'd0);
      check("async_state", 32'(dut.state), 32'd0);
      V_C = 1'b0;
`ifdef FOCUS_SAMPLE_CNT_EN
      check("cnt_reset", 32'(SAMPLE_CNT), 32'd0);
`endif
      @(posedge CLK); #1 RESET_n = 1'b1;

      // Reset reloads the skip counter: first strobe lost, next three scored.
      strobe(5000);
      expect_accept(10); strobe(10);
      expect_accept(20); strobe(20);
      expect_accept(30); strobe(30);
      check("peak_post_reset", 32'(PEAK_VAL), 32'd30);
`ifdef FOCUS_SAMPLE_CNT_EN
      check("cnt_three", 32'(SAMPLE_CNT), 32'd3);
`endif

      repeat (3) @(posedge CLK);
      #1;
      check("peak_q_drained", 32'(peak_q.size()), 32'd0);
      check("up_q_drained", 32'(up_q.size()), 32'd0);
      check("fin_q_drained", 32'(fin_q.size()), 32'd0);
      check("done_q_drained", 32'(done_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
